bram_arbiter: RTL and testbench
===============================

# bram_arbiter

Two-requester round-robin arbiter and sequencer in front of the 256 x 32-bit BRAM access controller. It accepts single-word write and multi-word burst-read commands from two clients, such as the image loader and the neuron-layer engine. It issues exactly one command at a time on the controller's trigger interface and routes the returned read stream and completion to the owning client. Commands are latched at grant, so clients need not hold them while the controller is busy.

## Interface
- ADDR_W, 8, word address width (controller address space)
- DATA_W, 32, data word width
- LEN_W, 8, burst length width (words)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- rN_req  in  1  (N=0,1) command request; held high until rN_gnt sampled high
- rN_write  in  1  1=single-word write, 0=burst read
- rN_addr  in  ADDR_W  write address / read start address
- rN_wdata  in  DATA_W  write data
- rN_len  in  LEN_W  read word count; 0 treated as 1
- rN_gnt  out  1  command accepted (combinational, IDLE only)
- rN_rvalid  out  1  read word valid on rdata
- rN_done  out  1  one-cycle pulse: owner's command finished
- rdata  out  DATA_W  shared read data (m_output_data passthrough)
- busy  out  1  state != IDLE
- m_read_or_write  out  1  to controller: 1=read, 0=write
- m_trigger_action  out  1  to controller trigger
- m_start_address  out  ADDR_W  to controller
- m_input_data  out  DATA_W  to controller
- m_no_of_bytes  out  LEN_W  to controller (word count)
- m_output_ready  in  1  from controller: read word valid
- m_output_data  in  DATA_W  from controller
- m_read_complete  in  1  from controller: last read word cycle

## Operation
- States: IDLE, ISSUE, READ.
- IDLE:
  - If any rN_req, select a winner: sole requester, or on a tie the requester other than last_grant.
  - Assert the winner's rN_gnt the same cycle.
  - At the edge: latch write/addr/wdata/len (len 0 becomes 1) into command registers, record owner, set last_grant=owner, go ISSUE.
- ISSUE:
  - m_trigger_action=1 for exactly one cycle; m_* driven from the command registers; m_read_or_write = ~cmd_write.
  - Write: go IDLE; owner's done pulses the next cycle.
  - Read: go READ.
- READ:
  - m_trigger_action=0; m_* held stable (controller reads start_address/no_of_bytes combinationally throughout the burst).
  - owner rvalid = m_output_ready; the other client's rvalid = 0.
  - On m_read_complete=1: go IDLE; owner's done pulses the next cycle.
- m_output_ready and m_read_complete are ignored outside READ.
- rN_gnt is never asserted outside IDLE, and never for both requesters.
- Address+len crossing 2^ADDR_W wraps modulo 2^ADDR_W; the arbiter passes the fields unchanged.
- A beat counter counts rvalid cycles in READ, for debug/assertions only. The bench checks beats == len at done.
- Reset (any time, including mid-burst):
  - state=IDLE, last_grant=1 (r0 wins the first tie), command registers cleared.
  - gnt/rvalid/done/busy/m_trigger_action/m_read_or_write = 0; m_start_address/m_input_data/m_no_of_bytes = 0.
  - In-flight command dropped with no done. The controller shares the reset.

## Timing
- Grant sampled at edge t (IDLE).
- ISSUE and trigger at cycle t+1; the write commits at the end of t+1.
- Write: done at t+2; IDLE at t+2, so the next grant is possible at t+2 (2-cycle write throughput).
- Read of N words:
  - rvalid on cycles t+2 .. t+1+N (N cycles, contiguous).
  - m_read_complete coincides with the last rvalid (t+1+N).
  - done at t+2+N; IDLE at t+2+N.
- rdata is valid only when rvalid=1.
- done is registered; gnt is combinational from req in IDLE; rvalid is combinational from m_output_ready.
- A request arriving in the same cycle as done is granted that cycle, since the arbiter is back in IDLE.

## Test plan
- **Single write.** Reset, then r0 writes addr 5, data 0x17.
  - Expect r0_gnt at t, m_trigger_action=1 with m_read_or_write=0 at t+1, r0_done at t+2.
  - Then r0 reads addr 5 len 1: one rvalid with rdata=0x17, done one cycle later.
- **Burst read.** Write 0..4 with 56,84,102,510,633; r1 reads addr 0 len 5.
  - Expect r1_rvalid for 5 contiguous cycles with rdata 56,84,102,510,633.
  - r1_done one cycle after the last beat; r0_rvalid stays 0 throughout.
- **Round-robin fairness.** r0 and r1 both hold req continuously with writes after reset.
  - Grants alternate r0,r1,r0,r1.
  - A new grant every 2 cycles; never both gnt high.
- **Wrap-around and len 0.**
  - Write 253,254,255,0 with 234,345,789,9; read addr 253 len 4. Expect 234,345,789,9.
  - Read len 0. Expect exactly 1 beat.
- **Reset mid-burst.** Assert reset during the 3rd beat of a len-8 read.
  - All outputs 0 immediately; no done.
  - After release, a fresh r1 request is granted at the first IDLE cycle.

Source files
------------

// File: rtl/bram_arbiter.sv
// Two-client round-robin arbiter/sequencer in front of the 256x32 BRAM access
// controller. Commands are latched at grant and one command is in flight at a time.
module bram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [LEN_W-1:0]  r0_len,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic              r0_done,
    input  logic              r1_req,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic [LEN_W-1:0]  r1_len,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic              r1_done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              m_read_or_write,
    output logic              m_trigger_action,
    output logic [ADDR_W-1:0] m_start_address,
    output logic [DATA_W-1:0] m_input_data,
    output logic [LEN_W-1:0]  m_no_of_bytes,
    input  logic              m_output_ready,
    input  logic [DATA_W-1:0] m_output_data,
    input  logic              m_read_complete
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, READ = 2'd2} state_t;

    state_t            state_reg, state_next;
    logic              last_grant_reg;
    logic              owner_reg;
    logic              cmd_write_reg;
    logic [ADDR_W-1:0] cmd_addr_reg;
    logic [DATA_W-1:0] cmd_wdata_reg;
    logic [LEN_W-1:0]  cmd_len_reg;
    logic [1:0]        done_reg, done_next;
    logic [LEN_W-1:0]  beat_cnt_reg;

    logic [1:0]        req, gnt, rvalid;
    logic              grant_any;
    logic              winner;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [LEN_W-1:0]  sel_len;

    assign req = {r1_req, r0_req};

    // Grant is combinational but must stay low while reset is held.
    assign grant_any = (state_reg == IDLE) && !reset && (req != 2'b00);

    always_comb begin
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last_grant_reg;
        end
    end

    assign sel_write = winner ? r1_write : r0_write;
    assign sel_addr  = winner ? r1_addr  : r0_addr;
    assign sel_wdata = winner ? r1_wdata : r0_wdata;
    assign sel_len   = winner ? r1_len   : r0_len;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_client
            assign gnt[gi]    = grant_any && (winner == 1'(gi));
            assign rvalid[gi] = (state_reg == READ) && (owner_reg == 1'(gi)) && m_output_ready;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        done_next  = 2'b00;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_write_reg) begin
                    state_next = IDLE;
                    done_next  = owner_reg ? 2'b10 : 2'b01;
                end else begin
                    state_next = READ;
                end
            end
            READ: begin
                if (m_read_complete) begin
                    state_next = IDLE;
                    done_next  = owner_reg ? 2'b10 : 2'b01;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            cmd_write_reg  <= 1'b0;
            cmd_addr_reg   <= '0;
            cmd_wdata_reg  <= '0;
            cmd_len_reg    <= '0;
            done_reg       <= 2'b00;
            beat_cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            if (grant_any) begin
                owner_reg      <= winner;
                last_grant_reg <= winner;
                cmd_write_reg  <= sel_write;
                cmd_addr_reg   <= sel_addr;
                cmd_wdata_reg  <= sel_wdata;
                cmd_len_reg    <= (sel_len == '0) ? LEN_W'(1) : sel_len;
                beat_cnt_reg   <= '0;
            end else if (state_reg == READ && m_output_ready) begin
                beat_cnt_reg <= beat_cnt_reg + LEN_W'(1);
            end
        end
    end

    assign r0_gnt    = gnt[0];
    assign r1_gnt    = gnt[1];
    assign r0_rvalid = rvalid[0];
    assign r1_rvalid = rvalid[1];
    assign r0_done   = done_reg[0];
    assign r1_done   = done_reg[1];
    assign rdata     = m_output_data;
    assign busy      = (state_reg != IDLE);

    // Direction is forced low in IDLE so the cleared command register reads as 0.
    assign m_trigger_action = (state_reg == ISSUE);
    assign m_read_or_write  = busy && !cmd_write_reg;
    assign m_start_address  = cmd_addr_reg;
    assign m_input_data     = cmd_wdata_reg;
    assign m_no_of_bytes    = cmd_len_reg;

    assert property (@(posedge clk) disable iff (reset) !(gnt[0] && gnt[1]));

    // The final beat arrives with m_read_complete, so one beat is still uncounted.
    assert property (@(posedge clk) disable iff (reset)
        (state_reg == READ && m_read_complete) |-> (beat_cnt_reg + LEN_W'(1) == cmd_len_reg));
endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: BRAM controller model, transaction-level expectation
// schedule checked every cycle, and directed tests with literal expectations.
module tb_bram_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int SLOTS = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic r0_req, r0_write, r1_req, r1_write;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic [LW-1:0] r0_len, r1_len;
    logic r0_gnt, r0_rvalid, r0_done, r1_gnt, r1_rvalid, r1_done;
    logic [DW-1:0] rdata;
    logic busy, m_read_or_write, m_trigger_action;
    logic [AW-1:0] m_start_address;
    logic [DW-1:0] m_input_data;
    logic [LW-1:0] m_no_of_bytes;
    logic m_output_ready, m_read_complete;
    logic [DW-1:0] m_output_data;

    bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_len(r0_len),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_done(r0_done),
        .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_len(r1_len),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_done(r1_done),
        .rdata(rdata), .busy(busy),
        .m_read_or_write(m_read_or_write), .m_trigger_action(m_trigger_action),
        .m_start_address(m_start_address), .m_input_data(m_input_data), .m_no_of_bytes(m_no_of_bytes),
        .m_output_ready(m_output_ready), .m_output_data(m_output_data), .m_read_complete(m_read_complete)
    );

    // ---------------- BRAM access controller model ----------------
    logic [DW-1:0] ctl_mem [256];
    logic          ctl_active;
    logic [7:0]    ctl_idx, ctl_len, ctl_addr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_active <= 1'b0;
            ctl_idx    <= '0;
            ctl_len    <= '0;
            ctl_addr   <= '0;
        end else begin
            if (m_trigger_action && !m_read_or_write) ctl_mem[m_start_address] <= m_input_data;
            if (m_trigger_action && m_read_or_write) begin
                ctl_active <= 1'b1;
                ctl_idx    <= '0;
                ctl_len    <= m_no_of_bytes;
                ctl_addr   <= m_start_address;
            end else if (ctl_active) begin
                if (ctl_idx == ctl_len - 8'd1) ctl_active <= 1'b0;
                ctl_idx <= ctl_idx + 8'd1;
            end
        end
    end
    assign m_output_ready  = ctl_active;
    assign m_read_complete = ctl_active && (ctl_idx == ctl_len - 8'd1);
    assign m_output_data   = ctl_active ? ctl_mem[8'(ctl_addr + ctl_idx)] : '0;

    // ---------------- counters and checker ----------------
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [DW-1:0] mdl_mem [256];
    int            free_at = 0;
    int            mdl_last = 1;
    logic          exp_trig [SLOTS];
    logic          exp_busy [SLOTS];
    logic          exp_mval [SLOTS];
    logic          exp_rv   [2][SLOTS];
    logic          exp_dn   [2][SLOTS];
    logic          exp_mrw  [SLOTS];
    logic [AW-1:0] exp_addr [SLOTS];
    logic [DW-1:0] exp_wd   [SLOTS];
    logic [LW-1:0] exp_len  [SLOTS];
    logic [DW-1:0] exp_rd   [SLOTS];

    function automatic void clear_slot(input int i);
        exp_trig[i] = 0; exp_busy[i] = 0; exp_mval[i] = 0; exp_mrw[i] = 0;
        exp_rv[0][i] = 0; exp_rv[1][i] = 0; exp_dn[0][i] = 0; exp_dn[1][i] = 0;
        exp_addr[i] = '0; exp_wd[i] = '0; exp_len[i] = '0; exp_rd[i] = '0;
    endfunction

    function automatic void set_cmd(input int i, input logic rd, input logic [AW-1:0] a,
                                    input logic [DW-1:0] d, input logic [LW-1:0] l);
        exp_busy[i] = 1; exp_mval[i] = 1; exp_mrw[i] = rd;
        exp_addr[i] = a; exp_wd[i] = d; exp_len[i] = l;
    endfunction

    initial for (int i = 0; i < SLOTS; i++) clear_slot(i);

    // Observation logs for the directed literal checks.
    int            gnt_cyc_q[$], gnt_who_q[$], beat_cyc_q[$], beat_who_q[$], done_cyc_q[$], done_who_q[$];
    logic [DW-1:0] beat_dat_q[$];

    always @(negedge clk) begin
        int s, w, n;
        logic [1:0] eg;
        logic wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [LW-1:0] l;
        s = cyc % SLOTS;
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) clear_slot(i);
            free_at = cyc;
            mdl_last = 1;
            chk("rst_gnt", {r1_gnt, r0_gnt}, 0);
            chk("rst_rvalid", {r1_rvalid, r0_rvalid}, 0);
            chk("rst_done", {r1_done, r0_done}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_trigger", m_trigger_action, 0);
            chk("rst_m_rw", m_read_or_write, 0);
            chk("rst_m_addr", m_start_address, 0);
            chk("rst_m_wdata", m_input_data, 0);
            chk("rst_m_len", m_no_of_bytes, 0);
        end else begin
            eg = 2'b00;
            if (cyc >= free_at && (r0_req || r1_req)) begin
                w = (r0_req && r1_req) ? (mdl_last == 1 ? 0 : 1) : (r0_req ? 0 : 1);
                eg[w] = 1'b1;
                if (w == 0) begin wr = r0_write; a = r0_addr; d = r0_wdata; l = r0_len; end
                else        begin wr = r1_write; a = r1_addr; d = r1_wdata; l = r1_len; end
                if (l == 0) l = 1;
                n = int'(l);
                exp_trig[(cyc + 1) % SLOTS] = 1;
                set_cmd((cyc + 1) % SLOTS, !wr, a, d, l);
                if (wr) begin
                    mdl_mem[a] = d;
                    exp_dn[w][(cyc + 2) % SLOTS] = 1;
                    free_at = cyc + 2;
                end else begin
                    for (int k = 0; k < n; k++) begin
                        set_cmd((cyc + 2 + k) % SLOTS, 1'b1, a, d, l);
                        exp_rv[w][(cyc + 2 + k) % SLOTS] = 1;
                        exp_rd[(cyc + 2 + k) % SLOTS] = mdl_mem[8'(a + 8'(k))];
                    end
                    exp_dn[w][(cyc + 2 + n) % SLOTS] = 1;
                    free_at = cyc + 2 + n;
                end
                mdl_last = w;
            end
            chk("gnt0", r0_gnt, eg[0]);
            chk("gnt1", r1_gnt, eg[1]);
            chk("gnt_exclusive", r0_gnt & r1_gnt, 0);
            chk("rvalid0", r0_rvalid, exp_rv[0][s]);
            chk("rvalid1", r1_rvalid, exp_rv[1][s]);
            chk("done0", r0_done, exp_dn[0][s]);
            chk("done1", r1_done, exp_dn[1][s]);
            chk("busy", busy, exp_busy[s]);
            chk("trigger", m_trigger_action, exp_trig[s]);
            if (exp_mval[s]) begin
                chk("m_rw", m_read_or_write, exp_mrw[s]);
                chk("m_addr", m_start_address, exp_addr[s]);
                chk("m_wdata", m_input_data, exp_wd[s]);
                chk("m_len", m_no_of_bytes, exp_len[s]);
            end
            if (exp_rv[0][s] || exp_rv[1][s]) chk("rdata", rdata, exp_rd[s]);
            if (r0_gnt) begin gnt_cyc_q.push_back(cyc); gnt_who_q.push_back(0); end
            if (r1_gnt) begin gnt_cyc_q.push_back(cyc); gnt_who_q.push_back(1); end
            if (r0_rvalid || r1_rvalid) begin
                beat_cyc_q.push_back(cyc); beat_who_q.push_back(r1_rvalid ? 1 : 0); beat_dat_q.push_back(rdata);
            end
            if (r0_done) begin done_cyc_q.push_back(cyc); done_who_q.push_back(0); end
            if (r1_done) begin done_cyc_q.push_back(cyc); done_who_q.push_back(1); end
        end
        clear_slot(s);
    end

    // ---------------- stimulus helpers ----------------
    logic [DW-1:0] lit [8];

    task automatic clear_logs();
        gnt_cyc_q.delete(); gnt_who_q.delete(); beat_cyc_q.delete(); beat_who_q.delete();
        beat_dat_q.delete(); done_cyc_q.delete(); done_who_q.delete();
    endtask

    task automatic drive(input int who, input logic rq, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [LW-1:0] l);
        if (who == 0) begin r0_req = rq; r0_write = wr; r0_addr = a; r0_wdata = d; r0_len = l; end
        else          begin r1_req = rq; r1_write = wr; r1_addr = a; r1_wdata = d; r1_len = l; end
    endtask

    task automatic do_cmd(input int who, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [LW-1:0] l);
        logic got;
        drive(who, 1'b1, wr, a, d, l);
        got = 1'b0;
        for (int b = 0; b < 50 && !got; b++) begin
            @(negedge clk);
            got = (who == 0) ? r0_gnt : r1_gnt;
            if (!got) begin @(posedge clk); #1; end
        end
        chk("gnt_wait", got, 1);
        @(posedge clk); #1;
        drive(who, 1'b0, 1'b0, '0, '0, '0);
        got = 1'b0;
        for (int b = 0; b < 300 && !got; b++) begin
            @(negedge clk);
            got = (who == 0) ? r0_done : r1_done;
        end
        chk("done_wait", got, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_read(input string tag, input int who, input int n);
        chk({tag, "_nbeats"}, beat_dat_q.size(), n);
        chk({tag, "_ndone"}, done_cyc_q.size(), 1);
        for (int k = 0; k < beat_dat_q.size() && k < n; k++) begin
            chk({tag, "_data"}, beat_dat_q[k], lit[k]);
            chk({tag, "_owner"}, beat_who_q[k], who);
            chk({tag, "_contig"}, beat_cyc_q[k] - beat_cyc_q[0], k);
        end
        if (beat_cyc_q.size() > 0 && gnt_cyc_q.size() > 0)
            chk({tag, "_first_beat_lat"}, beat_cyc_q[0] - gnt_cyc_q[0], 2);
        if (beat_cyc_q.size() > 0 && done_cyc_q.size() > 0)
            chk({tag, "_done_lat"}, done_cyc_q[0] - beat_cyc_q[beat_cyc_q.size() - 1], 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();

        // Single write then readback.
        do_cmd(0, 1'b1, 8'd5, 32'h17, 8'd0);
        chk("t1_ngnt", gnt_cyc_q.size(), 1);
        if (gnt_cyc_q.size() > 0 && done_cyc_q.size() > 0)
            chk("t1_write_done_lat", done_cyc_q[0] - gnt_cyc_q[0], 2);
        clear_logs();
        do_cmd(0, 1'b0, 8'd5, 32'h0, 8'd1);
        lit[0] = 32'h17;
        check_read("t1_read", 0, 1);

        // Burst read by r1.
        lit[0] = 56; lit[1] = 84; lit[2] = 102; lit[3] = 510; lit[4] = 633;
        for (int i = 0; i < 5; i++) do_cmd(0, 1'b1, 8'(i), lit[i], 8'd1);
        clear_logs();
        do_cmd(1, 1'b0, 8'd0, 32'h0, 8'd5);
        check_read("burst", 1, 5);

        // Wrap-around and len 0.
        lit[0] = 234; lit[1] = 345; lit[2] = 789; lit[3] = 9;
        for (int i = 0; i < 4; i++) do_cmd(1, 1'b1, 8'(253 + i), lit[i], 8'd0);
        clear_logs();
        do_cmd(0, 1'b0, 8'd253, 32'h0, 8'd4);
        check_read("wrap", 0, 4);
        clear_logs();
        do_cmd(1, 1'b0, 8'd253, 32'h0, 8'd0);
        check_read("len0", 1, 1);

        // Round-robin with both clients requesting continuously after reset.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
        drive(0, 1'b1, 1'b1, 8'd10, 32'd100, 8'd1);
        drive(1, 1'b1, 1'b1, 8'd11, 32'd200, 8'd1);
        repeat (8) @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rr_ngnt", gnt_who_q.size(), 4);
        for (int k = 0; k < gnt_who_q.size() && k < 4; k++) begin
            chk("rr_order", gnt_who_q[k], k % 2);
            chk("rr_spacing", gnt_cyc_q[k] - gnt_cyc_q[0], 2 * k);
        end

        // Reset during the third beat of a len-8 read.
        clear_logs();
        begin
            logic got;
            drive(0, 1'b1, 1'b0, 8'd0, 32'h0, 8'd8);
            got = 1'b0;
            for (int b = 0; b < 50 && !got; b++) begin
                @(negedge clk);
                got = r0_gnt;
                if (!got) begin @(posedge clk); #1; end
            end
            chk("mid_gnt_wait", got, 1);
            @(posedge clk); #1;
            drive(0, 1'b0, 1'b0, '0, '0, '0);
            repeat (3) @(posedge clk);
            #1;
            reset = 1'b1;
            drive(1, 1'b1, 1'b1, 8'd20, 32'habc, 8'd1);
            #1;
            chk("mid_busy", busy, 0);
            chk("mid_rvalid0", r0_rvalid, 0);
            chk("mid_trigger", m_trigger_action, 0);
            chk("mid_m_rw", m_read_or_write, 0);
            chk("mid_m_len", m_no_of_bytes, 0);
            chk("mid_gnt1_in_reset", r1_gnt, 0);
            chk("mid_beats_before_reset", beat_dat_q.size(), 2);
            @(posedge clk); #1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            chk("mid_fresh_gnt1", r1_gnt, 1);
            @(posedge clk); #1;
            drive(1, 1'b0, 1'b0, '0, '0, '0);
            repeat (4) @(posedge clk);
            #1;
            chk("mid_ndone", done_who_q.size(), 1);
            if (done_who_q.size() > 0) chk("mid_done_owner", done_who_q[0], 1);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
